main_top: RTL and testbench
===========================

// Module: main_top
//
// PURPOSE
// - Top-level board block: samples the slide switches and drives the LEDs with their
//   synchronized, debounced state (led[i] mirrors sw[i]).
// - Sits directly under the FPGA pins. Switches are asynchronous to clk; LEDs are
//   driven straight from registers.
//
// PARAMETERS
// - WIDTH            4  number of switch/LED pairs (>=1)
// - DEBOUNCE_CYCLES  4  consecutive clk cycles a new synchronized level must hold
//                       before it is accepted (>=1)
//
// PORTS
// - clk  in   1      system clock, all logic on rising edge
// - rst  in   1      reset, synchronous, active-high
// - sw   in   WIDTH  raw slide-switch inputs, asynchronous
// - led  out  WIDTH  LED drive, 1 = lit, registered
//
// BEHAVIOUR
// - Single clock domain (clk). rst is synchronous and active-high.
// - Reset: sync stages, accepted state, per-bit counters and led all clear to 0.
//   rst asserted mid-debounce discards the pending change.
// - Synchronizer: two flops per bit, s1 <= sw, s2 <= s1. Both are always present.
// - Debounce, independent per bit i, with accepted state acc[i]:
//   - s2[i]==acc[i]: cnt[i] <= 0.
//   - s2[i]!=acc[i] and cnt[i]==DEBOUNCE_CYCLES-1: acc[i] <= s2[i], cnt[i] <= 0.
//   - Otherwise: cnt[i] <= cnt[i]+1.
//   - Counter width is max(1, $clog2(DEBOUNCE_CYCLES)). The counter never wraps:
//     it is cleared at the terminal value.
// - Output: led <= acc each cycle.
// - Latency: sw changes before edge k and stays stable -> led updates at edge
//   k+2+DEBOUNCE_CYCLES (default: 6 cycles).
// - Glitch: a change shorter than DEBOUNCE_CYCLES synchronized cycles never reaches led.
// - Simultaneous bit changes debounce independently; equal timing gives the same
//   update edge.
//
// CONFIGURATION
// - MAIN_DEBOUNCE_EN defined: debounce filter as above.
// - MAIN_DEBOUNCE_EN undefined: no counters, acc <= s2 every cycle.
//   - Latency is 3 edges (led at k+3).
//   - DEBOUNCE_CYCLES is ignored.
//   - Glitches of 1+ cycles pass through.
//
// STRUCTURE
// - main_pkg: default WIDTH (4), default DEBOUNCE_CYCLES (4), reset value constant
//   (all zeros).
// - Sub-module sw_debounce: one bit, contains the 2-flop synchronizer plus the
//   counter/accept logic. It is instantiated WIDTH times in a generate loop.
// - main_top holds only the generate loop and the led output register.
//
// TESTING (10 ns clk, defaults, MAIN_DEBOUNCE_EN defined)
// - Reset:
//   - rst=1 for 3 cycles with sw=4'b1111 -> led=4'b0000 throughout.
//   - After release, led=4'b1111 at the 6th edge.
// - Steps: sw sequence 0000 -> 1010 -> 0101 -> 1111, each held 100 ns ->
//   led takes each value exactly 6 edges after the change and is stable between.
// - Glitch:
//   - sw[0] pulses high for 2 cycles -> led stays 0000.
//   - A pulse of 5 cycles -> led[0]=1 for a matching 5-cycle-long window.
// - Independence: sw[3] rises, sw[1] rises 2 cycles later -> led[3] rises at +6,
//   led[1] at +8.
// - Mid-reset: sw 0000->1111, then rst pulsed at +4 -> led=0000.
//   - After release, led=1111 6 edges later.
// - Macro off: sw 0000->1010 -> led=1010 at the 3rd edge.
//   - A 1-cycle glitch appears on led for 1 cycle.

Source files
------------

// File: rtl/main_pkg.sv
// Shared defaults for the switch/LED board block: widths, debounce length, reset value.
package main_pkg;

  localparam int   DEF_WIDTH           = 4;
  localparam int   DEF_DEBOUNCE_CYCLES = 4;
  localparam logic RST_VAL             = 1'b0;

  // Debounce counter width; a single-cycle filter still needs one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/main_sw_debounce.sv
// One switch bit: 2-flop synchronizer plus debounce filter producing the accepted level.
// MAIN_DEBOUNCE_EN selects the counter filter; without it acc follows the synchronizer directly.
module sw_debounce
  import main_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic acc
);

  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

`ifdef MAIN_DEBOUNCE_EN
  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Any return to the accepted level restarts the count, so short glitches are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= RST_VAL;
      cnt <= '0;
    end else if (s2 == acc) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      acc <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= RST_VAL;
    end else begin
      acc <= s2;
    end
  end
`endif

endmodule

// File: rtl/main_top.sv
// Board top: per-bit synchronize/debounce of slide switches, registered LED drive.
// Debounce filter enabled by defining MAIN_DEBOUNCE_EN.
module main_top
  import main_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] led
);

  logic [WIDTH-1:0] acc;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
      .clk (clk),
      .rst (rst),
      .sw  (sw[i]),
      .acc (acc[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led <= {WIDTH{RST_VAL}};
    end else begin
      led <= acc;
    end
  end

endmodule

// File: tb/tb_main_top.sv
// Directed bench for main_top: reset, steps, glitch filtering, per-bit independence, mid-debounce reset.
module tb_main_top;

`ifdef MAIN_DEBOUNCE_EN
  localparam int LAT      = 6;
  localparam int MIN_PASS = 4;
`else
  localparam int LAT      = 3;
  localparam int MIN_PASS = 1;
`endif
  localparam int HOLD = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] led;

  int n_tests = 0;
  int n_fail  = 0;

  main_top dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw),
    .led (led)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] exp);
    n_tests++;
    assert (led === exp)
    else begin
      n_fail++;
      $error("FAIL %s: led=%b expected %b", tag, led, exp);
    end
  endtask

  // Change sw and hold it: led keeps the old value for LAT edges, then takes the new one.
  task automatic step(input string tag, input logic [3:0] from, input logic [3:0] to);
    sw = to;
    repeat (LAT) begin
      tick();
      check(tag, from);
    end
    tick();
    check(tag, to);
    repeat (HOLD - LAT - 1) begin
      tick();
      check(tag, to);
    end
  endtask

  // High pulse of p cycles on sw[0]; it reaches led only if at least MIN_PASS long.
  task automatic pulse(input string tag, input int p);
    logic [3:0] exp;
    sw = 4'b0001;
    for (int t = 1; t <= p + LAT + 4; t++) begin
      tick();
      exp = (p >= MIN_PASS && t >= LAT + 1 && t <= LAT + p) ? 4'b0001 : 4'b0000;
      check(tag, exp);
      if (t == p) sw = 4'b0000;
    end
  endtask

  initial begin
    logic [3:0] exp;

    rst = 1'b1;
    sw  = 4'b1111;
    repeat (3) begin
      tick();
      check("reset_hold", 4'b0000);
    end
    rst = 1'b0;
    repeat (LAT) begin
      tick();
      check("reset_release_wait", 4'b0000);
    end
    tick();
    check("reset_release_on", 4'b1111);

    step("step_0000", 4'b1111, 4'b0000);
    step("step_1010", 4'b0000, 4'b1010);
    step("step_0101", 4'b1010, 4'b0101);
    step("step_1111", 4'b0101, 4'b1111);
    step("step_back_0000", 4'b1111, 4'b0000);

    pulse("glitch_1", 1);
    pulse("glitch_2", 2);
    pulse("glitch_3", 3);
    pulse("pulse_4", 4);
    pulse("pulse_5", 5);

    sw = 4'b1000;
    for (int t = 1; t <= LAT + 6; t++) begin
      tick();
      exp = {(t >= LAT + 1), 1'b0, (t >= LAT + 3), 1'b0};
      check("indep", exp);
      if (t == 2) sw = 4'b1010;
    end
    step("indep_clear", 4'b1010, 4'b0000);

    sw = 4'b1111;
    repeat (3) begin
      tick();
      check("mid_reset_pending", 4'b0000);
    end
    rst = 1'b1;
    tick();
    check("mid_reset_pulse", 4'b0000);
    rst = 1'b0;
    repeat (LAT) begin
      tick();
      check("mid_reset_wait", 4'b0000);
    end
    tick();
    check("mid_reset_on", 4'b1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
